// File: rtl/apb_master.sv
// APB4 requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and returns read data plus error status as a one-cycle response pulse.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_strb_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                busy_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pready_i,
  input  logic                pslverr_i
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e              state_q, state_d;
  logic                accept;
  logic                xfer_done;
  logic                timeout;
  logic [ADDR_W-1:0]   paddr_q;
  logic                pwrite_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  assign cmd_ready_o = (state_q == StIdle);
  assign accept      = cmd_ready_o & cmd_valid_i;
  // Select/enable decode straight from state so reset clears them asynchronously.
  assign psel_o      = (state_q != StIdle);
  assign penable_o   = (state_q == StAccess);
  assign busy_o      = psel_o;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wait_cnt_q;

  // Count stalled ACCESS cycles; cleared when a command enters SETUP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (accept) begin
      wait_cnt_q <= '0;
    end else if ((state_q == StAccess) && !pready_i) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Fires on the stalled cycle that brings the count to TIMEOUT_CYCLES;
  // a ready in that same cycle takes priority.
  assign timeout = (state_q == StAccess) && !pready_i &&
                   (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state decode for the SETUP/ACCESS sequence.
  always_comb begin
    state_d   = state_q;
    xfer_done = 1'b0;
    unique case (state_q)
      StIdle:   if (cmd_valid_i) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: begin
        if (pready_i || timeout) begin
          state_d   = StIdle;
          xfer_done = 1'b1;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Address/data phase registers: loaded on accept, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (accept) begin
      paddr_q  <= cmd_addr_i;
      pwrite_q <= cmd_write_i;
      pwdata_q <= cmd_wdata_i;
      pstrb_q  <= cmd_write_i ? cmd_strb_i : '0;
    end
  end

  // Response pulse; data and error hold until the next response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= xfer_done;
      if (xfer_done) begin
        if (pready_i) begin
          rsp_rdata_q <= pwrite_q ? '0 : prdata_i;
          rsp_err_q   <= pslverr_i;
        end else begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// transfers against a transaction-level timing model.
module tb_apb_master;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;
`ifdef APB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic [SW-1:0] cmd_strb_i;
  logic          rsp_valid_o, rsp_err_o, busy_o;
  logic [DW-1:0] rsp_rdata_o;
  logic [AW-1:0] paddr_o;
  logic          psel_o, penable_o, pwrite_o;
  logic [DW-1:0] pwdata_o, prdata_i;
  logic [SW-1:0] pstrb_o;
  logic          pready_i, pslverr_i;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;

  // Expected bus-side registers and last response contents.
  logic [AW-1:0] exp_addr   = '0;
  logic          exp_write  = 1'b0;
  logic [DW-1:0] exp_wdata  = '0;
  logic [SW-1:0] exp_strb   = '0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err   = 1'b0;

  apb_master #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i),
    .cmd_strb_i (cmd_strb_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .busy_o     (busy_o),
    .paddr_o    (paddr_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .pwdata_o   (pwdata_o),
    .pstrb_o    (pstrb_o),
    .prdata_i   (prdata_i),
    .pready_i   (pready_i),
    .pslverr_i  (pslverr_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_regs(input string ph);
    check({ph, "_paddr"},  64'(paddr_o),  64'(exp_addr));
    check({ph, "_pwrite"}, 64'(pwrite_o), 64'(exp_write));
    check({ph, "_pwdata"}, 64'(pwdata_o), 64'(exp_wdata));
    check({ph, "_pstrb"},  64'(pstrb_o),  64'(exp_strb));
  endtask

  task automatic chk_idle(input string ph);
    check({ph, "_psel"},    64'(psel_o),      64'(0));
    check({ph, "_penable"}, 64'(penable_o),   64'(0));
    check({ph, "_busy"},    64'(busy_o),      64'(0));
    check({ph, "_ready"},   64'(cmd_ready_o), 64'(1));
  endtask

  task automatic scramble_cmd();
    cmd_write_i = 1'($urandom);
    cmd_addr_i  = AW'($urandom);
    cmd_wdata_i = $urandom;
    cmd_strb_i  = SW'($urandom);
  endtask

  // Idle cycles with no command: response must not pulse and must hold.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid_i = 1'b0;
      scramble_cmd();
      @(negedge clk);
      check("idle_rsp_valid", 64'(rsp_valid_o), 64'(0));
      check("idle_rdata",     64'(rsp_rdata_o), 64'(last_rdata));
      check("idle_err",       64'(rsp_err_o),   64'(last_err));
      chk_idle("idle");
      chk_regs("idle");
    end
  endtask

  // One transfer, entered at a negedge with the DUT idle; returns at the
  // negedge of the response cycle so the next call can issue back-to-back.
  task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [SW-1:0] strb, input int waits,
                      input logic [DW-1:0] rdata, input bit slverr);
    bit timed_out;
    int n_acc;
    timed_out = TimeoutEn && (waits >= int'(TO));
    n_acc     = timed_out ? int'(TO) : waits + 1;
    // Accept cycle T
    check("acc_ready", 64'(cmd_ready_o), 64'(1));
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_strb_i  = strb;
    pready_i    = 1'($urandom);
    pslverr_i   = 1'($urandom);
    prdata_i    = $urandom;
    exp_addr  = addr;
    exp_write = wr;
    exp_wdata = wdata;
    exp_strb  = wr ? strb : '0;
    // SETUP at T+1
    @(negedge clk);
    check("setup_psel",      64'(psel_o),      64'(1));
    check("setup_penable",   64'(penable_o),   64'(0));
    check("setup_busy",      64'(busy_o),      64'(1));
    check("setup_ready",     64'(cmd_ready_o), 64'(0));
    check("setup_rsp_valid", 64'(rsp_valid_o), 64'(0));
    chk_regs("setup");
    cmd_valid_i = 1'($urandom);
    scramble_cmd();
    // ACCESS from T+2
    for (int j = 0; j < n_acc; j++) begin
      @(negedge clk);
      check("acc_psel",      64'(psel_o),      64'(1));
      check("acc_penable",   64'(penable_o),   64'(1));
      check("acc_ready_lo",  64'(cmd_ready_o), 64'(0));
      check("acc_rsp_valid", 64'(rsp_valid_o), 64'(0));
      chk_regs("acc");
      pready_i = !timed_out && (j == waits);
      if (pready_i) begin
        prdata_i  = rdata;
        pslverr_i = slverr;
      end else begin
        prdata_i  = $urandom;
        pslverr_i = 1'($urandom);
      end
      cmd_valid_i = 1'($urandom);
      scramble_cmd();
    end
    // Response cycle
    @(negedge clk);
    last_rdata = (timed_out || wr) ? '0 : rdata;
    last_err   = timed_out ? 1'b1 : slverr;
    check("rsp_valid", 64'(rsp_valid_o), 64'(1));
    check("rsp_rdata", 64'(rsp_rdata_o), 64'(last_rdata));
    check("rsp_err",   64'(rsp_err_o),   64'(last_err));
    chk_idle("rsp");
    chk_regs("rsp");
    cmd_valid_i = 1'b0;
    pready_i    = 1'($urandom);
  endtask

  initial begin
    int t0;
    reset       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    cmd_strb_i  = '0;
    prdata_i    = '0;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check("rst_rdata",     64'(rsp_rdata_o), 64'(0));
    check("rst_err",       64'(rsp_err_o),   64'(0));
    chk_idle("rst");
    chk_regs("rst");
    reset = 1'b0;
    idle(2);

    // Write with zero wait states
    xfer(1'b1, 12'h004, 32'h0000_00A5, 4'b0001, 0, 32'h1234_5678, 1'b0);
    idle(1);
    // Read with two wait states
    xfer(1'b0, 12'h008, 32'h5555_5555, 4'hF, 2, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    // Erroring read, then a good transfer back-to-back
    xfer(1'b0, 12'hFFC, 32'h0, 4'h0, 0, 32'hCAFE_0001, 1'b1);
    xfer(1'b1, 12'h00C, 32'h0BAD_F00D, 4'hC, 1, 32'h0, 1'b0);
    idle(1);

    // Three back-to-back writes: 9 cycles from first accept to last response
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      xfer(1'b1, AW'(12'h010 + 4 * k), $urandom, 4'hF, 0, $urandom, 1'b0);
    end
    check("b2b_cycles", 64'(cyc - t0), 64'(9));
    idle(2);

    // Long stall (times out when enabled), stall ending exactly on the
    // timeout boundary, then a normal transfer
    xfer(1'b0, 12'h020, 32'h0, 4'h0, int'(TO) + 3, 32'h7777_7777, 1'b0);
    xfer(1'b0, 12'h024, 32'h0, 4'h0, int'(TO) - 1, 32'h1357_9BDF, 1'b0);
    xfer(1'b1, 12'h028, 32'h2468_ACE0, 4'h3, 0, 32'h0, 1'b0);
    idle(1);

    // Reset pulsed during ACCESS
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b1;
    cmd_addr_i  = 12'h030;
    cmd_wdata_i = 32'hFFFF_0000;
    cmd_strb_i  = 4'hF;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    pready_i = 1'b0;
    check("pre_rst_penable", 64'(penable_o), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    chk_idle("mid_rst");
    @(negedge clk);
    reset      = 1'b0;
    exp_addr   = '0;
    exp_write  = 1'b0;
    exp_wdata  = '0;
    exp_strb   = '0;
    last_rdata = '0;
    last_err   = 1'b0;
    idle(3);

    // Randomized transfers with random gaps (0 = back-to-back)
    for (int n = 0; n < 60; n++) begin
      bit            wr;
      int            waits;
      int            gap;
      logic [DW-1:0] rd;
      wr    = 1'($urandom);
      waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20))
                                          : int'($urandom_range(0, 3));
      gap   = int'($urandom_range(0, 2));
      rd    = $urandom;
      xfer(wr, AW'($urandom), $urandom, SW'($urandom), waits, rd, 1'($urandom));
      if (gap > 0) idle(gap);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
